// File: rtl/perm_sequencer_if.sv
// Valid/ready bus carrying one permutation of N element indices per transfer.
// The rank field exists only when PERM_SEQ_RANK_EN is defined.
interface perm_sequencer_if #(
    parameter int N  = 6,
    parameter int IW = 3,
    parameter int RW = 10
);
    typedef logic [RW-1:0] rank_t;

    logic            prm_valid;
    logic            prm_ready;
    logic [N*IW-1:0] prm;
    logic            prm_last;
`ifdef PERM_SEQ_RANK_EN
    rank_t           rank;
`endif

    modport master (
        input  prm_ready,
`ifdef PERM_SEQ_RANK_EN
        output rank,
`endif
        output prm_valid,
        output prm,
        output prm_last
    );

    modport slave (
        output prm_ready,
`ifdef PERM_SEQ_RANK_EN
        input  rank,
`endif
        input  prm_valid,
        input  prm,
        input  prm_last
    );
endinterface

// File: rtl/perm_sequencer.sv
// Walks all permutations of N indices in lexicographic order, one per accepted transfer.
// Optional feature macro: PERM_SEQ_RANK_EN adds the rank counter and rank output.
module perm_sequencer #(
    parameter int N  = 6,
    parameter int IW = 3,
    parameter int RW = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    perm_sequencer_if.master prm_if
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    typedef logic [IW-1:0] elem_t;
    typedef logic [RW-1:0] rank_t;

    state_e          state_q;
    state_e          state_d;
    logic [N*IW-1:0] prm_q;
    logic [N*IW-1:0] prm_d;
    logic [N*IW-1:0] succ_s;
    logic            has_pivot_s;
    logic            last_s;
    logic            xfer_s;

    function automatic logic [N*IW-1:0] identity_perm();
        logic [N*IW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            v[k*IW +: IW] = elem_t'(k);
        end
        return v;
    endfunction

    // Lexicographic successor of prm_q: pivot, swap with rightmost larger element, reverse suffix.
    always_comb begin
        elem_t cur [N];
        elem_t swp [N];
        elem_t piv_val;
        elem_t sw_val;
        elem_t res;
        int    piv;
        int    jdx;
        logic  hit;

        has_pivot_s = 1'b0;
        succ_s      = '0;
        piv_val     = '0;
        sw_val      = '0;
        res         = '0;
        piv         = -1;
        jdx         = 0;
        hit         = 1'b0;

        for (int k = 0; k < N; k++) begin
            cur[k] = prm_q[k*IW +: IW];
        end

        for (int k = 0; k < N - 1; k++) begin
            hit         = (cur[k] < cur[k+1]);
            has_pivot_s = has_pivot_s | hit;
            piv         = hit ? k : piv;
            piv_val     = hit ? cur[k] : piv_val;
        end

        // The suffix right of the pivot is descending, so the last hit is the rightmost larger element.
        for (int k = 0; k < N; k++) begin
            hit    = (k > piv) && (cur[k] > piv_val);
            jdx    = hit ? k : jdx;
            sw_val = hit ? cur[k] : sw_val;
        end

        for (int k = 0; k < N; k++) begin
            swp[k] = (k == piv) ? sw_val : ((k == jdx) ? piv_val : cur[k]);
        end

        for (int k = 0; k < N; k++) begin
            res = swp[k];
            for (int m = 0; m < N; m++) begin
                res = ((k > piv) && (m == (N + piv - k))) ? swp[m] : res;
            end
            succ_s[k*IW +: IW] = res;
        end
    end

    assign last_s = ~has_pivot_s;
    assign xfer_s = (state_q == ST_RUN) & prm_if.prm_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides both start and a same-cycle transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (xfer_s && last_s) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        busy_o           = 1'b0;
        done_o           = 1'b0;
        prm_if.prm_valid = 1'b0;
        case (state_q)
            ST_RUN: begin
                busy_o           = 1'b1;
                prm_if.prm_valid = 1'b1;
            end
            ST_FIN:  done_o = 1'b1;
            default: done_o = 1'b0;
        endcase
    end

    // Permutation next value; outside RUN it rests at identity so a start needs no extra load.
    always_comb begin
        prm_d = prm_q;
        case (state_q)
            ST_RUN: begin
                if (abort_i) begin
                    prm_d = identity_perm();
                end else if (xfer_s) begin
                    prm_d = last_s ? identity_perm() : succ_s;
                end else begin
                    prm_d = prm_q;
                end
            end
            default: prm_d = identity_perm();
        endcase
    end

    // Permutation register.
    always_ff @(posedge clk) begin
        if (rst) begin
            prm_q <= identity_perm();
        end else begin
            prm_q <= prm_d;
        end
    end

    assign prm_if.prm      = prm_q;
    assign prm_if.prm_last = last_s;

`ifdef PERM_SEQ_RANK_EN
    rank_t rank_q;
    rank_t rank_d;

    // Rank next value tracks accepted transfers within a run.
    always_comb begin
        rank_d = rank_q;
        case (state_q)
            ST_RUN: begin
                if (abort_i) begin
                    rank_d = '0;
                end else if (xfer_s) begin
                    rank_d = last_s ? '0 : (rank_q + rank_t'(1));
                end else begin
                    rank_d = rank_q;
                end
            end
            default: rank_d = '0;
        endcase
    end

    // Rank register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rank_q <= '0;
        end else begin
            rank_q <= rank_d;
        end
    end

    assign prm_if.rank = rank_q;
`else
    // Without rank tracking the walk itself is unchanged.
`endif

endmodule
